// File: rtl/mem_responder.sv
`default_nettype none
//============================================================================
// Module      : mem_responder
// Description : Tagged memory responder. Loads are accepted with a tag from
//               a pool of `NUM_MEM_TAGS and return their word snapshot a
//               fixed MEM_LATENCY edges later; stores write immediately.
//               Optional macro MEM_BACKPRESSURE_EN refuses every request
//               whenever a free-running 2-bit counter reads 3.
// Revision    : 1.0 - initial release
//============================================================================

`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

package mem_responder_pkg;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  localparam int TAG_W = $clog2(`NUM_MEM_TAGS);
endpackage

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int MEM_DEPTH   = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  BUS_COMMAND            proc2mem_command,
  input  logic [31:0]           proc2mem_addr,
  input  logic [`DATA_SIZE-1:0] proc2mem_data,
  output logic [TAG_W-1:0]      mem2proc_response,
  output logic [`DATA_SIZE-1:0] mem2proc_data,
  output logic [TAG_W-1:0]      mem2proc_tag
);

  localparam int         NUM_TAGS   = `NUM_MEM_TAGS;
  localparam int         WORD_SHIFT = $clog2(`DATA_SIZE / 8);
  localparam int         IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [4:0] LAT        = 5'(MEM_LATENCY);

  // Storage and per-tag tracking state (tags are numbered 1..NUM_TAGS)
  logic [`DATA_SIZE-1:0] mem_q [MEM_DEPTH];
  logic                  busy_q [1:NUM_TAGS];
  logic                  busy_d [1:NUM_TAGS];
  logic [4:0]            cnt_q  [1:NUM_TAGS];
  logic [4:0]            cnt_d  [1:NUM_TAGS];
  logic [`DATA_SIZE-1:0] snap_q [1:NUM_TAGS];
  logic [`DATA_SIZE-1:0] snap_d [1:NUM_TAGS];
  logic [TAG_W-1:0]      ret_tag_q, ret_tag_d;
  logic [`DATA_SIZE-1:0] ret_data_q, ret_data_d;

  logic [31:0]      word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             in_range;
  logic             stall;
  logic [TAG_W-1:0] free_tag;
  logic [TAG_W-1:0] resp_raw;
  logic             load_acc;
  logic             store_acc;

  assign word_idx = proc2mem_addr >> WORD_SHIFT;
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign in_range = (word_idx < 32'(MEM_DEPTH));

`ifdef MEM_BACKPRESSURE_EN
  logic [1:0] bp_cnt_q, bp_cnt_d;

  // Free-running phase counter; phase 3 blocks every request
  always_comb begin
    bp_cnt_d = bp_cnt_q + 2'd1;
  end

  // Phase counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) bp_cnt_q <= 2'd0;
    else       bp_cnt_q <= bp_cnt_d;
  end

  assign stall = (bp_cnt_q == 2'd3);
`else
  assign stall = 1'b0;
`endif

  // Lowest-numbered idle tag; zero means the pool is exhausted
  always_comb begin
    free_tag = '0;
    for (int t = NUM_TAGS; t >= 1; t--) begin
      if (!busy_q[t]) free_tag = TAG_W'(t);
    end
  end

  // Request acceptance decision for the command currently on the bus
  always_comb begin
    resp_raw  = '0;
    load_acc  = 1'b0;
    store_acc = 1'b0;
    if (in_range && !stall) begin
      case (proc2mem_command)
        BUS_LOAD: begin
          if (free_tag != '0) begin
            load_acc = 1'b1;
            resp_raw = free_tag;
          end
        end
        BUS_STORE: begin
          store_acc = 1'b1;
          resp_raw  = TAG_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Reset must silence the response immediately, independent of the clock
  assign mem2proc_response = reset ? '0 : resp_raw;

  // Tag aging, return selection and new-load allocation
  always_comb begin
    busy_d     = busy_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    ret_tag_d  = '0;
    ret_data_d = '0;
    for (int t = 1; t <= NUM_TAGS; t++) begin
      if (busy_q[t]) begin
        if (cnt_q[t] == 5'd1) begin
          // Final edge of the latency window: present and release the tag
          busy_d[t]  = 1'b0;
          cnt_d[t]   = '0;
          ret_tag_d  = TAG_W'(t);
          ret_data_d = snap_q[t];
        end else begin
          cnt_d[t] = cnt_q[t] - 5'd1;
        end
      end
    end
    // A tag being released this edge is still busy now, so no collision
    if (load_acc) begin
      busy_d[free_tag] = 1'b1;
      cnt_d[free_tag]  = LAT;
      snap_d[free_tag] = mem_q[mem_idx];
    end
  end

  // Tag state and registered return outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int t = 1; t <= NUM_TAGS; t++) begin
        busy_q[t] <= 1'b0;
        cnt_q[t]  <= '0;
        snap_q[t] <= '0;
      end
      ret_tag_q  <= '0;
      ret_data_q <= '0;
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      ret_tag_q  <= ret_tag_d;
      ret_data_q <= ret_data_d;
    end
  end

  // Word storage; an accepted store lands on the acceptance edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < MEM_DEPTH; w++) mem_q[w] <= '0;
    end else if (store_acc) begin
      mem_q[mem_idx] <= proc2mem_data;
    end
  end

  assign mem2proc_tag  = ret_tag_q;
  assign mem2proc_data = ret_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
//============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder. Two instances (latency
//               4 and 20) share one stimulus stream; a per-tag due-time
//               scoreboard predicts responses and returns every cycle.
// Revision    : 1.0 - initial release
//============================================================================

`ifndef DATA_SIZE
`define DATA_SIZE 64
`endif
`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int NT    = `NUM_MEM_TAGS;
  localparam int DW    = `DATA_SIZE;
  localparam int TW    = $clog2(`NUM_MEM_TAGS);
  localparam int DEPTH = 1024;
  localparam int LAT0  = 4;
  localparam int LAT1  = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  BUS_COMMAND    cmd   = BUS_NONE;
  logic [31:0]   addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [TW-1:0] resp0, tag0, resp1, tag1;
  logic [DW-1:0] data0, data1;

  always #5 clock = ~clock;

  mem_responder #(.MEM_LATENCY(LAT0), .MEM_DEPTH(DEPTH)) dut0 (
    .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .mem2proc_response(resp0), .mem2proc_data(data0),
    .mem2proc_tag(tag0));

  mem_responder #(.MEM_LATENCY(LAT1), .MEM_DEPTH(DEPTH)) dut1 (
    .clock(clock), .reset(reset), .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wdata), .mem2proc_response(resp1), .mem2proc_data(data1),
    .mem2proc_tag(tag1));

  int checks = 0;
  int errors = 0;

  // Behavioural model: word array plus, per instance and tag, the absolute
  // edge number at which the load is due back and the data it must carry.
  logic [DW-1:0] mm   [DEPTH];
  bit            busy [2][1:NT];
  int            due  [2][1:NT];
  logic [DW-1:0] sd   [2][1:NT];
  int            exp_tag  [2];
  logic [DW-1:0] exp_data [2];
  int            exp_resp [2];
  int            lat  [2] = '{LAT0, LAT1};
  int            edge_n = 0;
  int            bpc = 0;

  // Last observed outputs, used by the hand-computed checks
  logic [TW-1:0] r0, r1, t0, t1;
  logic [DW-1:0] d0, d1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < DEPTH; w++) mm[w] = '0;
    for (int i = 0; i < 2; i++) begin
      exp_tag[i]  = 0;
      exp_data[i] = '0;
      for (int t = 1; t <= NT; t++) begin
        busy[i][t] = 1'b0;
        due[i][t]  = 0;
        sd[i][t]   = '0;
      end
    end
    bpc = 0;
  endtask

  // Starts at a negedge: hold reset for n cycles with a load on the bus,
  // checking that everything stays silent, then release at a negedge.
  task automatic apply_reset(input int n);
    reset = 1'b1;
    cmd   = BUS_LOAD;
    addr  = 32'h0;
    wdata = '0;
    model_clear();
    for (int k = 0; k < n; k++) begin
      #1;
      chk("rst_resp0", DW'(resp0), '0);
      chk("rst_resp1", DW'(resp1), '0);
      chk("rst_tag0",  DW'(tag0),  '0);
      chk("rst_data0", data0,      '0);
      chk("rst_tag1",  DW'(tag1),  '0);
      chk("rst_data1", data1,      '0);
      @(negedge clock);
    end
    reset = 1'b0;
    cmd   = BUS_NONE;
  endtask

  // Starts at a negedge: drive one command, check, advance one edge, model it.
  task automatic cycle(input BUS_COMMAND c, input logic [31:0] a, input logic [DW-1:0] d);
    logic [31:0] widx;
    bit          inr;
    bit          bp_ok;
    int          w;
    cmd = c; addr = a; wdata = d;
    #1;
    widx  = a >> $clog2(DW / 8);
    inr   = (widx < 32'(DEPTH));
    w     = int'(widx % 32'(DEPTH));
    bp_ok = 1'b1;
`ifdef MEM_BACKPRESSURE_EN
    bp_ok = (bpc != 3);
`endif
    for (int i = 0; i < 2; i++) begin
      exp_resp[i] = 0;
      if (inr && bp_ok) begin
        if (c == BUS_STORE) exp_resp[i] = 1;
        else if (c == BUS_LOAD) begin
          for (int t = 1; t <= NT && exp_resp[i] == 0; t++)
            if (!busy[i][t]) exp_resp[i] = t;
        end
      end
    end
    chk("resp0", DW'(resp0), DW'(exp_resp[0]));
    chk("resp1", DW'(resp1), DW'(exp_resp[1]));
    chk("tag0",  DW'(tag0),  DW'(exp_tag[0]));
    chk("data0", data0,      exp_data[0]);
    chk("tag1",  DW'(tag1),  DW'(exp_tag[1]));
    chk("data1", data1,      exp_data[1]);
    r0 = resp0; r1 = resp1; t0 = tag0; t1 = tag1; d0 = data0; d1 = data1;
    @(posedge clock);
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      exp_tag[i]  = 0;
      exp_data[i] = '0;
      for (int t = 1; t <= NT; t++) begin
        if (busy[i][t] && due[i][t] == edge_n) begin
          exp_tag[i]  = t;
          exp_data[i] = sd[i][t];
          busy[i][t]  = 1'b0;
        end
      end
      if (c == BUS_LOAD && exp_resp[i] != 0) begin
        busy[i][exp_resp[i]] = 1'b1;
        due[i][exp_resp[i]]  = edge_n + lat[i];
        sd[i][exp_resp[i]]   = mm[w];
      end
    end
    if (c == BUS_STORE && exp_resp[0] != 0) mm[w] = d;
    bpc = (bpc + 1) % 4;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(BUS_NONE, 32'h0, '0);
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    BUS_COMMAND  c;
    model_clear();
    @(negedge clock);
    apply_reset(2);

`ifndef MEM_BACKPRESSURE_EN
    // Store then load of the same word; return 4 edges after acceptance
    cycle(BUS_STORE, 32'h40, 64'hDEADBEEF_CAFEF00D);
    chk("lit_store_resp", DW'(r0), 1);
    cycle(BUS_LOAD, 32'h40, '0);
    chk("lit_load_resp", DW'(r0), 1);
    idle(4);
    chk("lit_no_early_ret", DW'(t0), 0);
    idle(1);
    chk("lit_ret_tag", DW'(t0), 1);
    chk("lit_ret_data", d0, 64'hDEADBEEF_CAFEF00D);
    idle(1);
    chk("lit_ret_one_cycle", DW'(t0), 0);

    // Load before store sees old data; later load sees new data
    cycle(BUS_LOAD, 32'h80, '0);
    chk("lit_ld80_resp", DW'(r0), 1);
    cycle(BUS_STORE, 32'h80, 64'h1234);
    idle(4);
    chk("lit_pre_store_tag", DW'(t0), 1);
    chk("lit_pre_store_data", d0, 0);
    cycle(BUS_LOAD, 32'h80, '0);
    idle(5);
    chk("lit_post_store_data", d0, 64'h1234);

    // Out-of-range requests are refused and leave memory untouched
    cycle(BUS_STORE, 32'h10000, {DW{1'b1}});
    chk("lit_oor_store", DW'(r0), 0);
    cycle(BUS_LOAD, 32'h10000, '0);
    chk("lit_oor_load", DW'(r0), 0);
    cycle(BUS_LOAD, 32'h0, '0);
    idle(5);
    chk("lit_word0_intact", d0, 0);

    // Reset with a load in flight: it is dropped and tag 1 is reissued
    idle(25);
    cycle(BUS_LOAD, 32'h40, '0);
    chk("lit_pre_rst_tag", DW'(r0), 1);
    cycle(BUS_NONE, 32'h0, '0);
    apply_reset(2);
    idle(6);
    cycle(BUS_LOAD, 32'h40, '0);
    chk("lit_post_rst_tag", DW'(r0), 1);
    idle(5);
    chk("lit_post_rst_data", d0, 0);

    // Pool exhaustion at latency 20, then reuse of the first freed tag
    apply_reset(1);
    for (int k = 0; k < 22; k++) begin
      cycle(BUS_LOAD, 32'(k * 8), '0);
      if (k < 15) chk("lit_pool_resp", DW'(r1), DW'(k + 1));
      else if (k < 21) chk("lit_pool_full", DW'(r1), 0);
      else begin
        chk("lit_pool_ret_tag", DW'(t1), 1);
        chk("lit_pool_reuse", DW'(r1), 1);
      end
    end
`endif

    // Randomised traffic over a small word set to provoke hazards and pool
    // exhaustion, with occasional out-of-range addresses and a mid-run reset
    apply_reset(1);
    for (int n = 0; n < 600; n++) begin
      if (n == 300) apply_reset(2);
      sel = int'($urandom_range(0, 9));
      if (sel < 2)      c = BUS_NONE;
      else if (sel < 6) c = BUS_LOAD;
      else if (sel < 9) c = BUS_STORE;
      else              c = BUS_COMMAND'(2'd3);
      sel = int'($urandom_range(0, 19));
      if (sel < 16)      a = (32'($urandom_range(0, 7)) << 3) | 32'($urandom_range(0, 7));
      else if (sel < 18) a = 32'($urandom_range(1020, 1023)) << 3;
      else if (sel < 19) a = 32'($urandom_range(1024, 1100)) << 3;
      else               a = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 3);
      cycle(c, a, {$urandom, $urandom});
    end
    idle(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, cycles from load acceptance edge to data return (legal 1..31).
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, number of `DATA_SIZE-bit words stored.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port proc2mem_command  input  BUS_COMMAND  BUS_NONE / BUS_LOAD / BUS_STORE request.
REQ-006 SHALL have port proc2mem_addr  input  32  byte address of request.
REQ-007 SHALL have port proc2mem_data  input  `DATA_SIZE  store data.
REQ-008 SHALL have port mem2proc_response  output  $clog2(`NUM_MEM_TAGS)  acceptance tag; 0 = refused/no request.
REQ-009 SHALL have port mem2proc_data  output  `DATA_SIZE  load return data.
REQ-010 SHALL have port mem2proc_tag  output  $clog2(`NUM_MEM_TAGS)  tag of returning load; 0 = no return this cycle.

Function
REQ-011 Word index SHALL be proc2mem_addr >> log2(`DATA_SIZE/8); address in range iff word index < MEM_DEPTH.
REQ-012 mem2proc_response SHALL be combinational from current command, address and tag state, valid in the same cycle the command is driven.
REQ-013 BUS_NONE, out-of-range address, or refused request SHALL give response 0 with no state change.
REQ-014 Tag pool SHALL be 1..`NUM_MEM_TAGS; per tag one busy bit and one latency down-counter.
REQ-015 In-range BUS_LOAD SHALL be accepted iff a tag is free; response = lowest-numbered free tag.
REQ-016 On acceptance edge: tag marked busy, counter loaded with MEM_LATENCY, word data snapshotted into per-tag buffer.
REQ-017 Exactly MEM_LATENCY edges after acceptance, mem2proc_tag/mem2proc_data SHALL be registered outputs holding tag/snapshot for one cycle; tag freed on that same edge.
REQ-018 Freed tag SHALL be allocatable to a load in the cycle it is presented on mem2proc_tag.
REQ-019 When no load returns, mem2proc_tag and mem2proc_data SHALL be 0.
REQ-020 In-range BUS_STORE SHALL always be accepted with response 1, write proc2mem_data to the word on the edge, consume no tag, produce no return.
REQ-021 Load accepted before a store to the same word SHALL return pre-store data; load accepted after SHALL return post-store data.
REQ-022 At most one acceptance per cycle; fixed latency guarantees at most one return per cycle.
REQ-023 All `NUM_MEM_TAGS tags busy: loads refused with response 0 until a tag frees.

Reset
REQ-024 Reset SHALL asynchronously clear all busy bits, counters, snapshot buffers and memory words to 0.
REQ-025 During and after reset mem2proc_tag = 0, mem2proc_data = 0; mem2proc_response = 0 while reset is high.
REQ-026 Loads in flight at reset SHALL be dropped and never returned; first load after reset gets tag 1.

Configuration
REQ-027 Macro MEM_BACKPRESSURE_EN defined: free-running 2-bit counter (reset 0, increments every cycle); when counter == 3 all requests (load and store) SHALL be refused with response 0.
REQ-028 Macro MEM_BACKPRESSURE_EN undefined: no counter exists; acceptance governed only by REQ-013..REQ-023.

Verification
REQ-029 Store 64'hDEADBEEF_CAFEF00D to 0x40 (response 1), next cycle load 0x40 -> response 1; 4 edges later mem2proc_tag=1, data=64'hDEADBEEF_CAFEF00D for one cycle.
REQ-030 MEM_LATENCY=20, 16 back-to-back loads -> responses 1..15 then 0; cycle tag 1 returns, a new load gets response 1.
REQ-031 Load 0x80 (mem 0), store 64'h1234 to 0x80 next cycle -> load returns data 0; later load 0x80 returns 64'h1234.
REQ-032 Load/store at 0x10000 with MEM_DEPTH=1024 -> response 0, memory unchanged, no mem2proc_tag activity.
REQ-033 Load accepted (tag 1), reset asserted 2 cycles later -> tag 1 never returned, outputs 0; post-reset load gets tag 1.
REQ-034 MEM_BACKPRESSURE_EN defined, load every cycle from reset release -> every 4th request (counter == 3) response 0, others tags in lowest-free order.
